// File: rtl/refresh_sched.sv
// Refresh scheduler: a period timer accrues refresh debt, acknowledged
// refreshes retire it, and RefReq/RefUrgent tell the DRAM controller how
// badly a refresh is needed. Debt saturates at MAX_DEBT and the sticky
// Overflow flag marks a lost refresh.
module refresh_sched #(
    parameter int PERIOD       = 250,
    parameter int TIMER_W      = 8,
    parameter int URGENT_LEVEL = 2,
    parameter int MAX_DEBT     = 7,
    parameter int DEBT_W       = 3
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              RefEn,
    input  logic              RefAck,
    input  logic              ClrOvf,
    output logic              RefReq,
    output logic              RefUrgent,
    output logic [DEBT_W-1:0] Debt,
    output logic              Overflow
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PERIOD - 1);
    localparam logic [DEBT_W-1:0]  DEBT_MAX   = DEBT_W'(MAX_DEBT);
    localparam logic [DEBT_W-1:0]  DEBT_URG   = DEBT_W'(URGENT_LEVEL);

    logic [TIMER_W-1:0] timer;
    logic               ackD;
    logic               tick;
    logic               ackEdge;
    logic [DEBT_W-1:0]  debtNext;
    logic               ovfSet;

    assign tick    = RefEn && (timer == TIMER_LAST);
    assign ackEdge = RefAck && !ackD;

    // Period timer: free-runs while enabled, parked at zero while disabled
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            timer <= '0;
        end else if (!RefEn || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMER_W'(1);
        end
    end

    // Ack history starts high so a pulse already in flight at reset release is ignored
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ackD <= 1'b1;
        end else begin
            ackD <= RefAck;
        end
    end

    // Next debt: a tick and an ack edge on the same cycle cancel each other out
    always_comb begin
        debtNext = Debt;
        ovfSet   = 1'b0;
        if (tick && !ackEdge) begin
            if (Debt == DEBT_MAX) begin
                ovfSet = 1'b1;
            end else begin
                debtNext = Debt + DEBT_W'(1);
            end
        end else if (ackEdge && !tick) begin
            if (Debt != '0) begin
                debtNext = Debt - DEBT_W'(1);
            end
        end
    end

    // Debt and request outputs move together, requests derived from next-state debt
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Debt      <= '0;
            RefReq    <= 1'b0;
            RefUrgent <= 1'b0;
        end else begin
            Debt      <= debtNext;
            RefReq    <= RefEn && (debtNext != '0);
            RefUrgent <= RefEn && (debtNext >= DEBT_URG);
        end
    end

    // Sticky lost-refresh flag; a new overflow beats a simultaneous clear
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Overflow <= 1'b0;
        end else if (ovfSet) begin
            Overflow <= 1'b1;
        end else if (ClrOvf) begin
            Overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_refresh_sched.sv
// Directed bench for refresh_sched with PERIOD=8, URGENT_LEVEL=2, MAX_DEBT=7.
module tb_refresh_sched;

    localparam int DEBT_W = 3;

    logic              CLK;
    logic              Reset;
    logic              RefEn;
    logic              RefAck;
    logic              ClrOvf;
    logic              RefReq;
    logic              RefUrgent;
    logic [DEBT_W-1:0] Debt;
    logic              Overflow;

    int totalChecks;
    int badChecks;

    typedef struct {
        logic        en;
        logic        ack;
        logic        clr;
        int          cycles;
        logic [2:0]  debt;
        logic        req;
        logic        urg;
        logic        ovf;
        string       name;
    } TestVec;

    TestVec vecs[23];

    refresh_sched #(
        .PERIOD(8),
        .TIMER_W(4),
        .URGENT_LEVEL(2),
        .MAX_DEBT(7),
        .DEBT_W(DEBT_W)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .RefEn(RefEn),
        .RefAck(RefAck),
        .ClrOvf(ClrOvf),
        .RefReq(RefReq),
        .RefUrgent(RefUrgent),
        .Debt(Debt),
        .Overflow(Overflow)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic TestVec mkVec(input logic en, input logic ack, input logic clr,
                                     input int cycles, input logic [2:0] debt,
                                     input logic req, input logic urg, input logic ovf,
                                     input string name);
        TestVec v;
        v.en = en; v.ack = ack; v.clr = clr; v.cycles = cycles;
        v.debt = debt; v.req = req; v.urg = urg; v.ovf = ovf; v.name = name;
        return v;
    endfunction

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic en, input logic ack, input logic clr, input int cycles);
        RefEn  = en;
        RefAck = ack;
        ClrOvf = clr;
        stepCycles(cycles);
    endtask

    task automatic checkOutput(input string name, input logic [2:0] expDebt,
                               input logic expReq, input logic expUrg, input logic expOvf);
        logic [5:0] got;
        logic [5:0] want;
        got  = {Debt, RefReq, RefUrgent, Overflow};
        want = {expDebt, expReq, expUrg, expOvf};
        totalChecks++;
        if (got !== want) begin
            badChecks++;
            $display("[TB] FAIL %s: got debt=%0d req=%b urg=%b ovf=%b, want debt=%0d req=%b urg=%b ovf=%b",
                     name, got[5:3], got[2], got[1], got[0], want[5:3], want[2], want[1], want[0]);
        end
    endtask

    task automatic doReset();
        Reset  = 1'b1;
        RefEn  = 1'b0;
        RefAck = 1'b0;
        ClrOvf = 1'b0;
        stepCycles(2);
        checkOutput("reset state", 3'd0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;

        // Cycle counts below are edges since RefEn rose; ticks land on multiples of 8
        vecs[0]  = mkVec(1, 0, 0,  7, 3'd0, 0, 0, 0, "before first tick");
        vecs[1]  = mkVec(1, 0, 0,  1, 3'd1, 1, 0, 0, "first tick");
        vecs[2]  = mkVec(1, 0, 0,  7, 3'd1, 1, 0, 0, "hold debt 1");
        vecs[3]  = mkVec(1, 0, 0,  1, 3'd2, 1, 1, 0, "second tick urgent");
        vecs[4]  = mkVec(1, 1, 0,  1, 3'd1, 1, 0, 0, "ack pulse 1 edge");
        vecs[5]  = mkVec(1, 1, 0,  1, 3'd1, 1, 0, 0, "ack pulse 1 held");
        vecs[6]  = mkVec(1, 0, 0,  1, 3'd1, 1, 0, 0, "ack pulse 1 low");
        vecs[7]  = mkVec(1, 1, 0,  2, 3'd0, 0, 0, 0, "ack pulse 2");
        vecs[8]  = mkVec(1, 0, 0,  1, 3'd0, 0, 0, 0, "ack pulse 2 low");
        vecs[9]  = mkVec(1, 0, 0, 25, 3'd3, 1, 1, 0, "ramp to 3");
        vecs[10] = mkVec(1, 1, 0,  1, 3'd3, 1, 1, 0, "tick with ack at 3");
        vecs[11] = mkVec(1, 1, 0,  1, 3'd3, 1, 1, 0, "ack held at 3");
        vecs[12] = mkVec(1, 0, 0,  1, 3'd3, 1, 1, 0, "ack low at 3");
        vecs[13] = mkVec(1, 0, 0, 37, 3'd7, 1, 1, 0, "saturate at 7");
        vecs[14] = mkVec(1, 0, 0,  1, 3'd7, 1, 1, 1, "overflow tick");
        vecs[15] = mkVec(1, 0, 1,  1, 3'd7, 1, 1, 0, "clear overflow");
        vecs[16] = mkVec(1, 0, 0,  6, 3'd7, 1, 1, 0, "wait for tick");
        vecs[17] = mkVec(1, 0, 1,  1, 3'd7, 1, 1, 1, "set beats clear");
        vecs[18] = mkVec(1, 0, 1,  1, 3'd7, 1, 1, 0, "clear again");
        vecs[19] = mkVec(1, 0, 0,  6, 3'd7, 1, 1, 0, "wait tick at max");
        vecs[20] = mkVec(1, 1, 0,  1, 3'd7, 1, 1, 0, "tick with ack at max");
        vecs[21] = mkVec(1, 1, 0,  1, 3'd7, 1, 1, 0, "ack held at max");
        vecs[22] = mkVec(1, 0, 0,  1, 3'd7, 1, 1, 0, "ack low at max");

        doReset();
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].en, vecs[i].ack, vecs[i].clr, vecs[i].cycles);
            checkOutput(vecs[i].name, vecs[i].debt, vecs[i].req, vecs[i].urg, vecs[i].ovf);
        end

        // Disable with debt 2, retire one refresh while disabled, re-enable
        doReset();
        applyStimulus(1, 0, 0, 16);
        checkOutput("two ticks", 3'd2, 1'b1, 1'b1, 1'b0);
        applyStimulus(1, 0, 0, 3);
        applyStimulus(0, 0, 0, 1);
        checkOutput("disable masks requests", 3'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("ack while disabled", 3'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("ack held while disabled", 3'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 10);
        checkOutput("no ticks while disabled", 3'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("re-enable exposes debt", 3'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 6);
        checkOutput("timer restarted", 3'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("tick 8 after enable", 3'd2, 1'b1, 1'b1, 1'b0);

        // Async reset in the middle of an ack pulse, released with ack still high
        doReset();
        applyStimulus(1, 0, 0, 32);
        checkOutput("debt 4 before reset", 3'd4, 1'b1, 1'b1, 1'b0);
        RefAck = 1'b1;
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("async reset immediate", 3'd0, 1'b0, 1'b0, 1'b0);
        stepCycles(2);
        checkOutput("held in reset", 3'd0, 1'b0, 1'b0, 1'b0);
        #2;
        Reset = 1'b0;
        stepCycles(1);
        checkOutput("release with ack high", 3'd0, 1'b0, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("ack still high", 3'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 1, 0, 1);
        checkOutput("spurious ack at zero", 3'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("no underflow", 3'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
